// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the time-shared S-box controller.
// The forward S-box is built from a field inverse plus the affine map.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int WORD_W  = 32;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        KEY,
        DRAIN
    } ctrl_state_t;

    typedef enum logic {
        GRANT_DATA,
        GRANT_KEY
    } grant_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x14, x15;
        logic [7:0] x30, x60, x120, x240;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x14  = gf_mul(x12, x2);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(x240, x14);
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v
             ^ {v[6:0], v[7]}
             ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]}
             ^ 8'h63;
    endfunction

endpackage

// File: rtl/s_box.sv
// Single AES forward S-box, purely combinational.
module s_box
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_i,
    output logic [BYTE_W-1:0] byte_o
);

    assign byte_o = sbox_fwd(byte_i);

endmodule

// File: rtl/sbox_lanes.sv
// LANES parallel S-boxes over a packed byte vector, lowest byte in lane 0.
module sbox_lanes
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [BYTE_W*LANES-1:0] lanes_i,
    output logic [BYTE_W*LANES-1:0] lanes_o
);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        s_box u_sbox (
            .byte_i (lanes_i[g*BYTE_W +: BYTE_W]),
            .byte_o (lanes_o[g*BYTE_W +: BYTE_W])
        );
    end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Shares LANES S-boxes between SubBytes (128b) and SubWord (32b) requests.
// Define SBOX_PIPE_EN to register lane outputs (adds one DRAIN cycle).
module sbox_share_ctrl
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               st_valid,
    output logic               st_ready,
    input  logic [STATE_W-1:0] st_in,
    output logic               st_done,
    output logic [STATE_W-1:0] st_out,
    input  logic               kw_valid,
    output logic               kw_ready,
    input  logic [WORD_W-1:0]  kw_in,
    output logic               kw_done,
    output logic [WORD_W-1:0]  kw_out,
    output logic               busy
);

    localparam int LW = BYTE_W * LANES;
    localparam logic [3:0] DATA_LAST = 4'(16 / LANES - 1);
    localparam logic [3:0] KEY_LAST  = 4'(4 / LANES - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("sbox_share_ctrl: LANES must be 1, 2 or 4");
    end

    ctrl_state_t        state_q;
    grant_t             last_grant_q;
    logic [3:0]         cnt_q;
    logic [STATE_W-1:0] work_q;
    logic [STATE_W-1:0] work_d;
    logic [STATE_W-1:0] st_out_q;
    logic [WORD_W-1:0]  kw_out_q;
    logic               st_done_q;
    logic               kw_done_q;

    logic               idle;
    logic               is_last;
    logic               done_now;
    logic               wr_en;
    logic [3:0]         wr_idx;
    logic [LW-1:0]      wr_data;
    logic [LW-1:0]      lane_in;
    logic [LW-1:0]      lane_out;

`ifdef SBOX_PIPE_EN
    logic [LW-1:0]      pipe_q;
    logic [3:0]         pipe_idx_q;
    logic               pipe_vld_q;
`endif

    assign idle = (state_q == IDLE);

    // Tie goes to whichever side was not served last
    assign st_ready = idle && st_valid
                   && (!kw_valid || last_grant_q == GRANT_KEY);
    assign kw_ready = idle && kw_valid
                   && (!st_valid || last_grant_q == GRANT_DATA);

    assign is_last = (cnt_q == ((state_q == KEY) ? KEY_LAST : DATA_LAST));

    assign lane_in = work_q[int'(cnt_q)*LW +: LW];

    sbox_lanes #(
        .LANES (LANES)
    ) u_lanes (
        .lanes_i (lane_in),
        .lanes_o (lane_out)
    );

`ifdef SBOX_PIPE_EN
    assign done_now = (state_q == DRAIN);
`else
    assign done_now = ((state_q == DATA) || (state_q == KEY)) && is_last;
`endif

    // Work register with the current write-back chunk merged in place
    always_comb begin
        work_d  = work_q;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        wr_data = lane_out;
`ifdef SBOX_PIPE_EN
        wr_en   = pipe_vld_q;
        wr_idx  = pipe_idx_q;
        wr_data = pipe_q;
`else
        wr_en   = (state_q == DATA) || (state_q == KEY);
`endif
        if (wr_en) begin
            work_d[int'(wr_idx)*LW +: LW] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_DATA;
            cnt_q        <= '0;
            work_q       <= '0;
            st_out_q     <= '0;
            kw_out_q     <= '0;
            st_done_q    <= 1'b0;
            kw_done_q    <= 1'b0;
`ifdef SBOX_PIPE_EN
            pipe_q       <= '0;
            pipe_idx_q   <= '0;
            pipe_vld_q   <= 1'b0;
`endif
        end else begin
            st_done_q <= 1'b0;
            kw_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (st_ready) begin
                        work_q       <= st_in;
                        cnt_q        <= '0;
                        last_grant_q <= GRANT_DATA;
                        state_q      <= DATA;
                    end else if (kw_ready) begin
                        work_q       <= {{(STATE_W-WORD_W){1'b0}}, kw_in};
                        cnt_q        <= '0;
                        last_grant_q <= GRANT_KEY;
                        state_q      <= KEY;
                    end
                end
                DATA, KEY: begin
                    work_q <= work_d;
                    cnt_q  <= is_last ? 4'd0 : cnt_q + 4'd1;
`ifdef SBOX_PIPE_EN
                    pipe_q     <= lane_out;
                    pipe_idx_q <= cnt_q;
                    pipe_vld_q <= 1'b1;
                    if (is_last) begin
                        state_q <= DRAIN;
                    end
`else
                    if (is_last) begin
                        state_q <= IDLE;
                    end
`endif
                end
                default: begin
                    work_q  <= work_d;
`ifdef SBOX_PIPE_EN
                    pipe_vld_q <= 1'b0;
`endif
                    state_q <= IDLE;
                end
            endcase
            // last_grant_q still names the side that owns the op
            if (done_now) begin
                if (last_grant_q == GRANT_DATA) begin
                    st_out_q  <= work_d;
                    st_done_q <= 1'b1;
                end else begin
                    kw_out_q  <= work_d[WORD_W-1:0];
                    kw_done_q <= 1'b1;
                end
            end
        end
    end

    assign st_out  = st_out_q;
    assign st_done = st_done_q;
    assign kw_out  = kw_out_q;
    assign kw_done = kw_done_q;
    assign busy    = !idle;

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Self-checking bench for sbox_share_ctrl: vector table, corner
// sequences, LANES sweep and a randomized run against a cycle model.
module tb_sbox_share_ctrl;

`ifdef SBOX_PIPE_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif
    localparam int DLAT = 4 + PX;
    localparam int KLAT = 1 + PX;

    localparam logic [127:0] SB_ROWS [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk;
    logic         rst;
    logic         st_valid, st_ready, st_done;
    logic [127:0] st_in, st_out;
    logic         kw_valid, kw_ready, kw_done;
    logic [31:0]  kw_in, kw_out;
    logic         busy;

    logic         s1_valid, s1_ready, s1_done, s1_kwr, s1_kwd, s1_busy;
    logic         s2_valid, s2_ready, s2_done, s2_kwr, s2_kwd, s2_busy;
    logic [127:0] sw_in, s1_out, s2_out;
    logic [31:0]  s1_kwo, s2_kwo;

    int n_chk;
    int n_pass;

    sbox_share_ctrl #(.LANES(4)) u_dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in),
        .st_done(st_done), .st_out(st_out),
        .kw_valid(kw_valid), .kw_ready(kw_ready), .kw_in(kw_in),
        .kw_done(kw_done), .kw_out(kw_out),
        .busy(busy)
    );

    sbox_share_ctrl #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst),
        .st_valid(s1_valid), .st_ready(s1_ready), .st_in(sw_in),
        .st_done(s1_done), .st_out(s1_out),
        .kw_valid(1'b0), .kw_ready(s1_kwr), .kw_in(32'h0),
        .kw_done(s1_kwd), .kw_out(s1_kwo),
        .busy(s1_busy)
    );

    sbox_share_ctrl #(.LANES(2)) u_l2 (
        .clk(clk), .rst(rst),
        .st_valid(s2_valid), .st_ready(s2_ready), .st_in(sw_in),
        .st_done(s2_done), .st_out(s2_out),
        .kw_valid(1'b0), .kw_ready(s2_kwr), .kw_in(32'h0),
        .kw_done(s2_kwd), .kw_out(s2_kwo),
        .busy(s2_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [127:0] r;
        r = SB_ROWS[x[7:4]];
        return r[127 - 8*int'(x[3:0]) -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x,
                                               input int nb);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < nb; i++) begin
            r[8*i +: 8] = sb(x[8*i +: 8]);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered in the cycle right after the accept edge; returns at the
    // negedge of the done cycle (or after the bound expires).
    task automatic wait_done(input bit key, input int lat,
                             input logic [127:0] exp, input string nm);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        for (int i = 0; i <= lat + 8; i++) begin
            @(negedge clk);
            if ((key ? kw_done : st_done) === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, " latency"}, got ? 128'(n) : '1, 128'(lat));
        if (got) begin
            chk({nm, " value"}, key ? 128'(kw_out) : st_out, exp);
        end
    endtask

    task automatic run_op(input bit key, input logic [127:0] din,
                          input logic [127:0] exp, input string nm);
        if (key) begin
            kw_in    = din[31:0];
            kw_valid = 1'b1;
        end else begin
            st_in    = din;
            st_valid = 1'b1;
        end
        @(negedge clk);
        chk({nm, " ready"}, 128'(key ? kw_ready : st_ready), 128'(1'b1));
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        kw_valid = 1'b0;
        wait_done(key, key ? KLAT : DLAT, exp, nm);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit           key;
        logic [127:0] din;
        logic [127:0] exp;
        string        nm;
    } vec_t;

    vec_t         vecs [7];
    logic [127:0] last_st;
    logic [127:0] last_kw;
    bit           ord [4];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        st_valid = 1'b0;
        kw_valid = 1'b0;
        st_in = '0;
        kw_in = '0;
        s1_valid = 1'b0;
        s2_valid = 1'b0;
        sw_in = '0;

        vecs[0] = '{1'b0, 128'h0f0e0d0c0b0a09080706050403020100,
                    128'h76abd7fe2b670130c56f6bf27b777c63, "v_data_seq"};
        vecs[1] = '{1'b1, 128'hcf4f3c09,
                    128'h8a84eb01, "v_key_fips"};
        vecs[2] = '{1'b0, 128'h0,
                    128'h63636363636363636363636363636363, "v_data_zero"};
        vecs[3] = '{1'b0, '1,
                    128'h16161616161616161616161616161616, "v_data_ones"};
        vecs[4] = '{1'b1, 128'hffffffff,
                    128'h16161616, "v_key_ones"};
        vecs[5] = '{1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                    128'hd42711aee0bf98f1b8b45de51e415230, "v_data_fips"};
        vecs[6] = '{1'b1, 128'h0,
                    128'h63636363, "v_key_zero"};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset ctl", 128'({st_ready, kw_ready, busy, st_done, kw_done}),
            128'(5'b0));
        chk("reset st_out", st_out, '0);
        chk("reset kw_out", 128'(kw_out), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Vector table; the other side's result must be left alone
        last_st = '0;
        last_kw = '0;
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].key, vecs[i].din, vecs[i].exp, vecs[i].nm);
            if (vecs[i].key) begin
                last_kw = vecs[i].exp;
                chk({vecs[i].nm, " st_out held"}, st_out, last_st);
            end else begin
                last_st = vecs[i].exp;
                chk({vecs[i].nm, " kw_out held"}, 128'(kw_out), last_kw);
            end
        end

        // Both requesters held high after reset: key, data, key, data
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        st_in = vecs[0].din;
        kw_in = vecs[1].din[31:0];
        st_valid = 1'b1;
        kw_valid = 1'b1;
        ord = '{1'b1, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("arb%0d grant", i), 128'({st_ready, kw_ready}),
                128'({!ord[i], ord[i]}));
            @(posedge clk);
            #1;
            wait_done(ord[i], ord[i] ? KLAT : DLAT,
                      ord[i] ? vecs[1].exp : vecs[0].exp,
                      $sformatf("arb%0d", i));
        end
        st_valid = 1'b0;
        kw_valid = 1'b0;
        @(posedge clk);
        #1;

        // Key request arriving mid data-op waits for the data done cycle
        st_in = vecs[5].din;
        st_valid = 1'b1;
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        @(posedge clk);
        #1;
        kw_in = 32'h00000000;
        kw_valid = 1'b1;
        begin
            int n;
            bit got;
            n = 0;
            got = 1'b0;
            for (int i = 0; i < DLAT + 8; i++) begin
                @(negedge clk);
                if (st_done === 1'b1) begin
                    got = 1'b1;
                    break;
                end
                chk("midop kw_ready low", 128'(kw_ready), 128'(1'b0));
                @(posedge clk);
                #1;
                n++;
            end
            chk("midop data latency", got ? 128'(n + 1) : '1, 128'(DLAT));
            chk("midop kw_ready in done", 128'(kw_ready), 128'(1'b1));
            chk("midop st_out", st_out, vecs[5].exp);
        end
        @(posedge clk);
        #1;
        kw_valid = 1'b0;
        wait_done(1'b1, KLAT, 128'h63636363, "midop key");
        @(posedge clk);
        #1;

        // Reset during data beat 2 discards the op
        st_in = vecs[0].din;
        st_valid = 1'b1;
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid st_out", st_out, '0);
        chk("rstmid kw_out", 128'(kw_out), '0);
        chk("rstmid busy", 128'(busy), 128'(1'b0));
        for (int i = 0; i < DLAT + 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("rstmid no done", 128'({st_done, busy}), 128'(2'b0));
        end
        @(posedge clk);
        #1;
        run_op(1'b0, vecs[3].din, vecs[3].exp, "rstmid recover");

        // LANES sweep: 1 and 2 lanes on the same vector
        sw_in = vecs[0].din;
        s1_valid = 1'b1;
        s2_valid = 1'b1;
        @(negedge clk);
        chk("sweep ready", 128'({s1_ready, s2_ready}), 128'(2'b11));
        @(posedge clk);
        #1;
        s1_valid = 1'b0;
        s2_valid = 1'b0;
        begin
            int n1, n2;
            n1 = -1;
            n2 = -1;
            for (int n = 0; n < 30; n++) begin
                @(negedge clk);
                if (s1_done === 1'b1 && n1 < 0) begin
                    n1 = n;
                    chk("sweep l1 value", s1_out, vecs[0].exp);
                end
                if (s2_done === 1'b1 && n2 < 0) begin
                    n2 = n;
                    chk("sweep l2 value", s2_out, vecs[0].exp);
                end
                if (n1 >= 0 && n2 >= 0) begin
                    break;
                end
                @(posedge clk);
                #1;
            end
            chk("sweep l1 latency", 128'(n1), 128'(16 + PX));
            chk("sweep l2 latency", 128'(n2), 128'(8 + PX));
            chk("sweep idle", 128'({s1_busy, s2_busy, s1_kwd, s2_kwd,
                                    s1_kwr, s2_kwr}), 128'(6'b0));
            chk("sweep kw_out", 128'({s1_kwo, s2_kwo}), '0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic against a timeline model
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        begin
            int free_at, sd_at, kd_at;
            bit m_last_key, idle, gs, gk;
            logic [127:0] m_st, m_kw, st_pend, kw_pend;
            free_at = 0;
            sd_at = -1;
            kd_at = -1;
            m_last_key = 1'b0;
            m_st = '0;
            m_kw = '0;
            st_pend = '0;
            kw_pend = '0;
            for (int c = 0; c < 1500; c++) begin
                if (!st_valid && $urandom_range(0, 2) == 0) begin
                    st_valid = 1'b1;
                    st_in = {$urandom, $urandom, $urandom, $urandom};
                end
                if (!kw_valid && $urandom_range(0, 2) == 0) begin
                    kw_valid = 1'b1;
                    kw_in = $urandom;
                end
                idle = (c >= free_at);
                gs = idle && st_valid && (!kw_valid || m_last_key);
                gk = idle && kw_valid && (!st_valid || !m_last_key);
                if (c == sd_at) m_st = st_pend;
                if (c == kd_at) m_kw = kw_pend;
                @(negedge clk);
                chk("rnd ctl",
                    128'({st_ready, kw_ready, busy, st_done, kw_done}),
                    128'({gs, gk, !idle, c == sd_at, c == kd_at}));
                chk("rnd st_out", st_out, m_st);
                chk("rnd kw_out", 128'(kw_out), 128'(m_kw[31:0]));
                if (gs) begin
                    st_pend = sub_bytes(st_in, 16);
                    sd_at = c + 1 + DLAT;
                    free_at = sd_at;
                    m_last_key = 1'b0;
                end
                if (gk) begin
                    kw_pend = sub_bytes(128'(kw_in), 4);
                    kd_at = c + 1 + KLAT;
                    free_at = kd_at;
                    m_last_key = 1'b1;
                end
                @(posedge clk);
                #1;
                if (gs) st_valid = 1'b0;
                if (gk) kw_valid = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
